// File: rtl/sid_pkg.sv
// rtl/sid_pkg.sv - shared widths, register map constants and write-record type
// Ports: none (package).
package sid_pkg;

    localparam int ADDR_W  = 3;
    localparam int VOICE_W = 2;
    localparam int DATA_W  = 8;

    // Per-voice register addresses (voice 0..2)
    localparam logic [ADDR_W-1:0] FREQ_LO = 3'd0;
    localparam logic [ADDR_W-1:0] FREQ_HI = 3'd1;
    localparam logic [ADDR_W-1:0] PW_LO   = 3'd2;
    localparam logic [ADDR_W-1:0] PW_HI   = 3'd3;
    localparam logic [ADDR_W-1:0] AD      = 3'd4;
    localparam logic [ADDR_W-1:0] SR      = 3'd5;
    localparam logic [ADDR_W-1:0] WAV     = 3'd6;

    // Filter/global bank register addresses (voice 3)
    localparam logic [ADDR_W-1:0] FC_LO    = 3'd0;
    localparam logic [ADDR_W-1:0] FC_HI    = 3'd1;
    localparam logic [ADDR_W-1:0] RES_FILT = 3'd2;
    localparam logic [ADDR_W-1:0] MODE_VOL = 3'd3;

    localparam logic [VOICE_W-1:0] VOICE_FILT = 2'd3;

    typedef struct packed {
        logic [VOICE_W-1:0] voice;
        logic [ADDR_W-1:0]  addr;
        logic [DATA_W-1:0]  data;
    } wr_rec_t;

endpackage

// File: rtl/sid_host_wr_if_if.sv
// rtl/sid_host_wr_if_if.sv - register-file write bus (valid/ready handshake)
// Signals: wr_valid, wr_addr, wr_voice, wr_data (producer to register file),
//          wr_ready (register file to producer).
interface sid_host_wr_if_if;
    import sid_pkg::*;

    logic               wr_valid;
    logic [ADDR_W-1:0]  wr_addr;
    logic [VOICE_W-1:0] wr_voice;
    logic [DATA_W-1:0]  wr_data;
    logic               wr_ready;

    modport master (output wr_valid, wr_addr, wr_voice, wr_data, input wr_ready);
    modport slave  (input wr_valid, wr_addr, wr_voice, wr_data, output wr_ready);
endinterface

// File: rtl/sid_wr_fifo.sv
// rtl/sid_wr_fifo.sv - first-word fall-through queue of write records
// Ports: clk, rst_n, push/push_rec (enqueue), pop (dequeue head), head (front
//        record, last popped value while empty), empty, level, overflow (sticky).
module sid_wr_fifo
    import sid_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  wr_rec_t                  push_rec,
    input  logic                     pop,
    output wr_rec_t                  head,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    wr_rec_t         mem [DEPTH];
    wr_rec_t         last_q;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            full;
    logic            pop_ok;
    logic            push_ok;

    assign empty   = (level == '0);
    assign full    = (level == LW'(DEPTH));
    assign pop_ok  = pop & ~empty;
    // When full, a push is only accepted if the head leaves in the same cycle;
    // the new record then lands in the slot being vacated.
    assign push_ok = push & (~full | pop_ok);

    // Outputs hold the most recently popped record while the queue is empty.
    assign head = empty ? last_q : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_rec;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            last_q   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PW'(1);
                last_q <= mem[rd_ptr];
            end
            if (push & ~push_ok) begin
                overflow <= 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/sid_host_wr_if.sv
// rtl/sid_host_wr_if.sv - host register-write front end: strobe sync, edge detect, write queue
// Ports: clk, rst_n; host_we (async strobe), host_addr/host_voice/host_data;
//        wr (master side of the register-file write bus); wr_overflow; wr_level.
module sid_host_wr_if
    import sid_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEPTH       = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    host_we,
    input  logic [ADDR_W-1:0]       host_addr,
    input  logic [VOICE_W-1:0]      host_voice,
    input  logic [DATA_W-1:0]       host_data,
    sid_host_wr_if_if.master        wr,
    output logic                    wr_overflow,
    output logic [$clog2(DEPTH):0]  wr_level
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   rise;
    logic                   fifo_empty;
    wr_rec_t                push_rec;
    wr_rec_t                head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], host_we};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

    // Address/voice/data are sampled raw: the host keeps them stable across
    // the whole synchroniser delay, so only the strobe needs synchronising.
    assign push_rec = {host_voice, host_addr, host_data};

    sid_wr_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (rise),
        .push_rec (push_rec),
        .pop      (wr.wr_valid & wr.wr_ready),
        .head     (head),
        .empty    (fifo_empty),
        .level    (wr_level),
        .overflow (wr_overflow)
    );

    assign wr.wr_valid = ~fifo_empty;
    assign wr.wr_addr  = head.addr;
    assign wr.wr_voice = head.voice;
    assign wr.wr_data  = head.data;

endmodule

// File: doc/sid_host_wr_if.md
Name: sid_host_wr_if

Overview:
- Upstream front end of tt_um_sid.
- Takes the asynchronous host register-write port (addr/voice/data plus a level strobe driven from pins), synchronises the strobe and detects its rising edge.
- Captures each write into a small queue and presents it to the SID register file over a valid/ready handshake.
- Decouples pin timing from the register file's voice time-multiplexing; the register file may stall writes while a voice slot is being processed.

Parameters:
- SYNC_STAGES, 2, flip-flops in the strobe synchroniser; legal values 2..3.
- DEPTH, 4, write-queue entries; power of two, 2..8.

Ports:
- clk  in  1  system clock, 24 MHz.
- rst_n  in  1  asynchronous active-low reset.
- host_we  in  1  write strobe (ui_in[7]), asynchronous level.
- host_addr  in  3  register address (ui_in[2:0]).
- host_voice  in  2  voice select (ui_in[4:3]); 3 selects the filter/global bank.
- host_data  in  8  write data (uio_in).
- wr_valid  out  1  queue head holds a pending write.
- wr_addr  out  3  head address.
- wr_voice  out  2  head voice.
- wr_data  out  8  head data.
- wr_ready  in  1  register file accepts the head this cycle.
- wr_overflow  out  1  sticky: a write was dropped because the queue was full.
- wr_level  out  $clog2(DEPTH)+1  current queue occupancy.

Behaviour:
- Reset, asynchronous, on rst_n low:
  - synchroniser and edge flop cleared; queue emptied; pointers 0.
  - wr_valid=0, wr_addr=0, wr_voice=0, wr_data=0, wr_overflow=0, wr_level=0.
- Synchroniser: host_we passes through SYNC_STAGES flops. One further flop holds the previous synchronised value.
  - edge = sync_out & ~prev.
  - Exactly one edge pulse per strobe rise. A strobe held high never re-triggers.
- Capture: in the cycle edge=1, host_addr/host_voice/host_data are sampled directly (not synchronised).
  - Host contract: these are stable from 1 clk before the strobe rises until SYNC_STAGES+1 clks after.
  - Host contract: strobe high ≥2 clks and low ≥2 clks between writes.
- Latency: with SYNC_STAGES=2, a strobe rise sampled at posedge P1 yields edge during the cycle after P2. The entry is pushed at P3, and wr_valid=1 after P3.
- Queue: first-word fall-through. wr_addr/wr_voice/wr_data always reflect the head entry while wr_valid=1; they hold their last values while empty.
  - pop = wr_valid & wr_ready.
  - push = edge.
  - push & ~full: write entry, advance write pointer (wraps at DEPTH).
  - push & full & ~pop: write dropped, wr_overflow set to 1; sticky until reset.
  - push & full & pop: both happen, level unchanged, no overflow.
  - push & empty: the entry appears at the head the next cycle. There is no same-cycle bypass to wr_valid.
  - pop & empty: impossible by construction, because wr_valid=0.
  - Simultaneous push and pop at any non-full level: level unchanged, order preserved.
- wr_level is a registered count, 0..DEPTH.
- Handshake rules: wr_valid, once asserted, stays high and the head stays stable until popped. wr_ready may toggle freely.
- Reset mid-operation: queued writes are lost. If the strobe is still high when rst_n releases, the synchroniser comes up 0 and then sees 1, so one edge fires. The host must deassert the strobe before releasing reset.

Decomposition:
- sid_pkg holds:
  - address width 3, voice width 2, data width 8.
  - register address constants: FREQ_LO..WAV = 0..6; FC_LO, FC_HI, RES_FILT, MODE_VOL = 0..3.
  - VOICE_FILT = 3.
  - a packed write-record typedef {voice, addr, data}, 13 bits.
- One sub-module, sid_wr_fifo: a DEPTH-entry FWFT queue of write records with push/pop/full/empty/level and the overflow flag.
- Synchroniser and edge detect stay in sid_host_wr_if.

Test Plan:
- Single write: addr=0, voice=0, data=0x24, strobe high 2 clks, wr_ready=1 → wr_valid=1 exactly 3 posedges after strobe rise, head {0,0,0x24}, one cycle only, wr_level returns 0.
- Back-pressure order: wr_ready=0, four writes (0x11, 0x99, 0xA9, 0x0F) to voices 0/0/0/3 → wr_level=4, wr_overflow=0. Then wr_ready=1 → popped in order over 4 consecutive cycles.
- Overflow: wr_ready=0, five writes → fifth dropped, wr_overflow=1 and stays 1. Drained contents are the first four writes only.
- Full with simultaneous pop: queue full, wr_ready pulsed high in the same cycle as the edge of a fifth write → no overflow, wr_level stays 4, fifth write emerges last.
- Long strobe: strobe held high 50 clks with data=0x4F → exactly one entry queued.
- Async reset: assert rst_n low mid-queue (level=3) between clock edges → all outputs 0 immediately. After release with strobe low, no spurious write.
